// File: rtl/vga_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and helpers for the VGA scan engine: scan segment
//               encoding, the per-pixel pipeline payload, axis total and sync
//               window arithmetic, and a parameter legality check evaluated
//               at elaboration time by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Segment order along either axis.
    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FP     = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BP     = 2'd3
    } scan_seg_t;

    // Per-pixel payload carried through the read-latency pipeline.
    typedef struct packed {
        logic hs;     // raw sync window (active-high, before polarity)
        logic vs;
        logic vis;    // visible pixel
        logic fetch;  // this pixel issued a frame-buffer read
        logic first;  // first visible pixel of the frame
    } pipe_t;

    function automatic int unsigned vga_axis_total(input int unsigned active,
                                                   input int unsigned fp,
                                                   input int unsigned sync,
                                                   input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned vga_sync_start(input int unsigned active,
                                                   input int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned vga_sync_end(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync);
        return active + fp + sync;
    endfunction

    // Returns 1 when the parameter combination is legal.
    function automatic bit vga_cfg_ok(input int unsigned h_active,
                                      input int unsigned v_active,
                                      input int unsigned clk_div,
                                      input int unsigned scale,
                                      input int unsigned rd_lat,
                                      input int unsigned addr_w);
        bit          ok;
        int unsigned words;
        ok = 1'b1;
        if (clk_div < 1) ok = 1'b0;
        if (rd_lat < 1)  ok = 1'b0;
        if (scale != 1 && scale != 2 && scale != 4 && scale != 8) begin
            ok = 1'b0;
        end else begin
            if ((h_active % scale) != 0 || (v_active % scale) != 0) ok = 1'b0;
            words = (h_active * v_active) / (scale * scale);
            if (addr_w < $clog2(words)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One scan axis (horizontal or vertical). Counts 0..TOTAL-1 on
//               each advance, decodes the current segment and sync window and
//               flags the wrap.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear to count 0 (dominates adv_i)
//   adv_i        : advance one position
//   count_o      : current position
//   seg_o        : current segment (ACTIVE, FP, SYNC, BP)
//   sync_o       : 1 while inside the sync segment
//   wrap_o       : 1 when this advance moves TOTAL-1 back to 0
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CNT_W  = $clog2(vga_axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] count_o,
    output scan_seg_t        seg_o,
    output logic             sync_o,
    output logic             wrap_o
);

    localparam int unsigned      TOTAL        = vga_axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_FP_START   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC_START = CNT_W'(vga_sync_start(ACTIVE, FP));
    localparam logic [CNT_W-1:0] C_BP_START   = CNT_W'(vga_sync_end(ACTIVE, FP, SYNC));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (adv_i) begin
            count_d = (count_q == C_LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        if (count_q < C_FP_START) begin
            seg_o = SEG_ACTIVE;
        end else if (count_q < C_SYNC_START) begin
            seg_o = SEG_FP;
        end else if (count_q < C_BP_START) begin
            seg_o = SEG_SYNC;
        end else begin
            seg_o = SEG_BP;
        end
    end

    assign count_o = count_q;
    assign sync_o  = (seg_o == SEG_SYNC);
    assign wrap_o  = adv_i && !clr_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_scan_engine.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : vga_scan_engine
// Description : Parametrised VGA scan engine. Generates H/V timing from a
//               divided pixel tick, fetches pixels from a linear frame buffer
//               with integer replication, and drives RGB, sync and blank
//               aligned through an RD_LAT-deep pipeline.
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   en_i           : scan enable; low clears the scan synchronously
//   pxl_i          : frame-buffer read data {r,g,b}
//   addr_o, rd_o   : frame-buffer read address and one-clk read strobe
//   hs_o, vs_o     : horizontal / vertical sync (polarity SYNC_POL)
//   blank_o        : 1 during visible video
//   sync_o         : composite sync, constant 0
//   r_o, g_o, b_o  : colour channels, 0 outside the visible region
//   frame_o        : one-clk pulse on the first visible pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SCALE    = 1,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [3*COLOR_W-1:0]   pxl_i,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   rd_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   blank_o,
    output logic                   sync_o,
    output logic [COLOR_W-1:0]     r_o,
    output logic [COLOR_W-1:0]     g_o,
    output logic [COLOR_W-1:0]     b_o,
    output logic                   frame_o
);

    if (!vga_cfg_ok(H_ACTIVE, V_ACTIVE, CLK_DIV, SCALE, RD_LAT, ADDR_W)) begin : g_cfg_check
        $error("vga_scan_engine: illegal parameter combination");
    end

    localparam int unsigned H_TOTAL = vga_axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned XS_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned PXL_W   = 3 * COLOR_W;

    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [XS_W-1:0]   C_XS_LAST   = XS_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] C_LINE_STEP = ADDR_W'(H_ACTIVE / SCALE);
    localparam logic              C_SYNC_IDLE = ~SYNC_POL;

    // ------------------------------------------------------------------
    // Pixel tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    assign tick = en_i && (div_q == C_DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (!en_i || (div_q == C_DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Axis counters
    // ------------------------------------------------------------------
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    scan_seg_t      h_seg, v_seg;
    logic           h_sync, v_sync, h_wrap, v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (H_W)
    ) u_h_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!en_i),
        .adv_i   (tick),
        .count_o (h_count),
        .seg_o   (h_seg),
        .sync_o  (h_sync),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (V_W)
    ) u_v_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!en_i),
        .adv_i   (h_wrap),
        .count_o (v_count),
        .seg_o   (v_seg),
        .sync_o  (v_sync),
        .wrap_o  (v_wrap)
    );

    logic vis;
    logic fetch;

    assign vis   = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);

    // ------------------------------------------------------------------
    // Incremental address generator.
    // xs/ys are the sub-pixel positions inside a replicated pixel; hcol is
    // the source column within the line and line_base the first address of
    // the current source line. Only adders are used.
    // ------------------------------------------------------------------
    logic [XS_W-1:0]   xs_q, xs_d;
    logic [XS_W-1:0]   ys_q, ys_d;
    logic [ADDR_W-1:0] hcol_q, hcol_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;

    assign fetch = tick && vis && (xs_q == '0);

    always_comb begin
        xs_d        = xs_q;
        ys_d        = ys_q;
        hcol_d      = hcol_q;
        line_base_d = line_base_q;
        if (!en_i) begin
            xs_d        = '0;
            ys_d        = '0;
            hcol_d      = '0;
            line_base_d = '0;
        end else if (tick) begin
            if (vis) begin
                if (xs_q == C_XS_LAST) begin
                    xs_d   = '0;
                    hcol_d = hcol_q + 1'b1;
                end else begin
                    xs_d = xs_q + 1'b1;
                end
            end
            if (h_wrap) begin
                xs_d   = '0;
                hcol_d = '0;
                if (v_wrap) begin
                    ys_d        = '0;
                    line_base_d = '0;
                end else if (v_seg == SEG_ACTIVE) begin
                    // Step to the next source line after SCALE output lines.
                    if (ys_q == C_XS_LAST) begin
                        ys_d        = '0;
                        line_base_d = line_base_q + C_LINE_STEP;
                    end else begin
                        ys_d = ys_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        rd_d   = fetch;
        if (!en_i) begin
            addr_d = '0;
        end else if (fetch) begin
            addr_d = line_base_q + hcol_q;
        end
    end

    // ------------------------------------------------------------------
    // Read-latency pipeline: entry 0 captures the current scan position on
    // a tick; the last entry lines up with pxl_i arriving for that position.
    // ------------------------------------------------------------------
    pipe_t pipe_q [RD_LAT];
    pipe_t pipe_d [RD_LAT];
    pipe_t stage_in;
    pipe_t last;

    always_comb begin
        stage_in       = '0;
        stage_in.hs    = h_sync;
        stage_in.vs    = v_sync;
        stage_in.vis   = vis;
        stage_in.fetch = vis && (xs_q == '0);
        stage_in.first = (h_count == '0) && (v_count == '0);
    end

    always_comb begin
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (!en_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] = '0;
            end
        end else if (tick) begin
            pipe_d[0] = stage_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[RD_LAT-1];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             frame_q, frame_d;
    logic [PXL_W-1:0] rgb_q, rgb_d;
    logic [PXL_W-1:0] pix_q, pix_d;   // last fetched word, reused for replicas

    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        rgb_d   = rgb_q;
        pix_d   = pix_q;
        frame_d = 1'b0;
        if (!en_i) begin
            hs_d    = C_SYNC_IDLE;
            vs_d    = C_SYNC_IDLE;
            blank_d = 1'b0;
            rgb_d   = '0;
            pix_d   = '0;
        end else if (tick) begin
            hs_d    = last.hs ? SYNC_POL : C_SYNC_IDLE;
            vs_d    = last.vs ? SYNC_POL : C_SYNC_IDLE;
            blank_d = last.vis;
            frame_d = last.first;
            if (last.fetch) begin
                pix_d = pxl_i;
            end
            if (!last.vis) begin
                rgb_d = '0;
            end else if (last.fetch) begin
                rgb_d = pxl_i;
            end else begin
                rgb_d = pix_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q       <= '0;
            xs_q        <= '0;
            ys_q        <= '0;
            hcol_q      <= '0;
            line_base_q <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            hs_q        <= C_SYNC_IDLE;
            vs_q        <= C_SYNC_IDLE;
            blank_q     <= 1'b0;
            frame_q     <= 1'b0;
            rgb_q       <= '0;
            pix_q       <= '0;
        end else begin
            div_q       <= div_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            hcol_q      <= hcol_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            frame_q     <= frame_d;
            rgb_q       <= rgb_d;
            pix_q       <= pix_d;
        end
    end

    assign addr_o  = addr_q;
    assign rd_o    = rd_q;
    assign hs_o    = hs_q;
    assign vs_o    = vs_q;
    assign blank_o = blank_q;
    assign sync_o  = 1'b0;
    assign frame_o = frame_q;
    assign r_o     = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign g_o     = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign b_o     = rgb_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_engine.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_engine
// Description : Self-checking bench for vga_scan_engine with a reduced timing
//               (24x13 total, 16x8 visible, SCALE 2, CLK_DIV 2, RD_LAT 3,
//               positive sync). Expected outputs come from a position model:
//               after k pixel ticks the scan sits at position k mod frame,
//               the fetch seen on the pins is one tick old and sync, blank,
//               colour and frame are RD_LAT+1 ticks old.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_engine;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int DIV = 2, S = 2, LAT = 3, AW = 6, CW = 4;
    localparam bit POL = 1'b1;

    logic              clk   = 1'b0;
    logic              rst_i = 1'b0;
    logic              en_i  = 1'b0;
    logic [3*CW-1:0]   pxl_i = '0;
    logic [AW-1:0]     addr_o;
    logic              rd_o, hs_o, vs_o, blank_o, sync_o, frame_o;
    logic [CW-1:0]     r_o, g_o, b_o;

    vga_scan_engine #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
        .SYNC_POL (POL), .CLK_DIV (DIV), .SCALE (S), .RD_LAT (LAT),
        .ADDR_W (AW), .COLOR_W (CW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .pxl_i   (pxl_i),
        .addr_o  (addr_o),
        .rd_o    (rd_o),
        .hs_o    (hs_o),
        .vs_o    (vs_o),
        .blank_o (blank_o),
        .sync_o  (sync_o),
        .r_o     (r_o),
        .g_o     (g_o),
        .b_o     (b_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state
    int              tk   = 0;   // ticks since the scan (re)started
    int              dcnt = 0;   // clk cycles into the current pixel
    logic [AW-1:0]   e_addr;
    logic            e_rd, e_hs, e_vs, e_blank, e_frame;
    logic [3*CW-1:0] e_rgb;
    bit              hv [LAT];   // memory model: read pending, newest at 0
    int              ha [LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic int p_h(input int q); return q % HT; endfunction
    function automatic int p_v(input int q); return (q % FRAME) / HT; endfunction
    function automatic bit p_vis(input int q); return (p_h(q) < HA) && (p_v(q) < VA); endfunction
    function automatic bit p_hs(input int q);
        return (p_h(q) >= HA + HF) && (p_h(q) < HA + HF + HSY);
    endfunction
    function automatic bit p_vs(input int q);
        return (p_v(q) >= VA + VF) && (p_v(q) < VA + VF + VSY);
    endfunction
    function automatic int p_addr(input int q);
        return (p_v(q) / S) * (HA / S) + p_h(q) / S;
    endfunction
    function automatic logic [3*CW-1:0] mem_word(input int a);
        logic [3*CW-1:0] w;
        w = 12'((a * 149 + 7) % 4096);
        return w;
    endfunction

    task automatic set_idle();
        e_addr  = '0;
        e_rd    = 1'b0;
        e_hs    = !POL;
        e_vs    = !POL;
        e_blank = 1'b0;
        e_rgb   = '0;
        e_frame = 1'b0;
        dcnt    = 0;
        tk      = 0;
        for (int i = 0; i < LAT; i++) begin
            hv[i] = 1'b0;
            ha[i] = 0;
        end
        pxl_i = 12'($urandom);
    endtask

    task automatic compare_all();
        chk("addr",  32'(addr_o),  32'(e_addr));
        chk("rd",    32'(rd_o),    32'(e_rd));
        chk("hs",    32'(hs_o),    32'(e_hs));
        chk("vs",    32'(vs_o),    32'(e_vs));
        chk("blank", 32'(blank_o), 32'(e_blank));
        chk("sync",  32'(sync_o),  32'd0);
        chk("rgb",   32'({r_o, g_o, b_o}), 32'(e_rgb));
        chk("frame", 32'(frame_o), 32'(e_frame));
    endtask

    task automatic step();
        bit tick;
        int q;
        @(posedge clk);
        tick = 1'b0;
        if (rst_i || !en_i) begin
            set_idle();
        end else begin
            if (dcnt == DIV - 1) begin
                dcnt = 0;
                tick = 1'b1;
                tk++;
            end else begin
                dcnt++;
            end
            e_rd    = 1'b0;
            e_frame = 1'b0;
            if (tick) begin
                q = tk - 1;
                if (p_vis(q) && (p_h(q) % S) == 0) begin
                    e_rd   = 1'b1;
                    e_addr = AW'(p_addr(q));
                end
                q = tk - LAT - 1;
                if (q >= 0) begin
                    e_hs    = p_hs(q) ? POL : !POL;
                    e_vs    = p_vs(q) ? POL : !POL;
                    e_blank = p_vis(q);
                    e_rgb   = p_vis(q) ? mem_word(p_addr(q)) : '0;
                    e_frame = (q % FRAME) == 0;
                end
            end
        end
        #1;
        compare_all();
        if (tick) begin
            // Memory answers a read RD_LAT ticks later; otherwise garbage.
            for (int i = LAT - 1; i > 0; i--) begin
                hv[i] = hv[i-1];
                ha[i] = ha[i-1];
            end
            hv[0] = rd_o;
            ha[0] = int'(addr_o);
            pxl_i = hv[LAT-1] ? mem_word(ha[LAT-1]) : 12'($urandom);
        end
    endtask

    task automatic reset_pulse(input int hold);
        rst_i = 1'b1;
        #1;
        set_idle();
        compare_all();
        repeat (hold) step();
        rst_i = 1'b0;
    endtask

    task automatic drop_enable(input int len);
        en_i = 1'b0;
        repeat (len) step();
        en_i = 1'b1;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #1;
        set_idle();
        compare_all();
        repeat (3) step();
        rst_i = 1'b0;
        en_i  = 1'b1;

        // Two full frames plus margin from a clean start.
        repeat (1400) step();

        // Enable dropped for 10 clk in the middle of a visible line.
        for (int k = 0; k < 4 * FRAME * DIV && !(p_h(tk) == 8 && p_v(tk) == 3); k++) step();
        chk("reach_en_pos", 32'(tk % FRAME), 32'(3 * HT + 8));
        drop_enable(10);
        repeat (800) step();

        // Asynchronous reset mid-frame at h=12, v=5.
        for (int k = 0; k < 4 * FRAME * DIV && (tk % FRAME) != 5 * HT + 12; k++) step();
        chk("reach_rst_pos", 32'(tk % FRAME), 32'(5 * HT + 12));
        reset_pulse(3);
        repeat (800) step();

        // Random disturbances.
        for (int it = 0; it < 6; it++) begin
            repeat (int'($urandom_range(400, 50))) step();
            if ($urandom_range(1, 0) == 1) begin
                drop_enable(int'($urandom_range(12, 1)));
            end else begin
                reset_pulse(int'($urandom_range(3, 1)));
            end
        end
        repeat (700) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine that generates horizontal and vertical timing, drives a linear frame-buffer read port, and outputs pipeline-aligned RGB with matching sync and blank signals. It sits between the frame-buffer memory and the board's video DAC. It is the configurable successor of the fixed-mode VGA controller. Beyond fixed 640x480 timing, it adds programmable porches and sync polarity, an integer pixel-clock divider, integer pixel replication (scaling), read-latency compensation, and a frame-start marker.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, and back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, and back porch in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- CLK_DIV, 2, clk_i cycles per pixel; must be ≥1
- SCALE, 1, pixel replication factor in both axes; must be 1, 2, 4 or 8, and must divide H_ACTIVE and V_ACTIVE
- RD_LAT, 1, frame-buffer read latency in pixel ticks; must be ≥1
- ADDR_W, 19, address width; must be ≥ clog2(H_ACTIVE*V_ACTIVE/SCALE²), checked at elaboration
- COLOR_W, 8, bits per colour channel
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  scan enable
- pxl_i  in  3*COLOR_W  read data, packed {r,g,b}
- addr_o  out  ADDR_W  frame-buffer read address
- rd_o  out  1  read strobe; one clk wide per fetched pixel
- hs_o, vs_o  out  1  horizontal and vertical sync
- blank_o  out  1  active-low blank: 1 during visible video, 0 otherwise
- sync_o  out  1  composite sync; tied to 0
- r_o, g_o, b_o  out  COLOR_W  colour channels
- frame_o  out  1  one-clk pulse on the first visible pixel of each frame

## Operation
- Pixel tick: a divider counts 0..CLK_DIV-1 while en_i=1, and the tick fires when the count reaches CLK_DIV-1. With CLK_DIV=1 the tick fires every cycle. All scan state advances only on ticks.
- Horizontal counter h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. Segment order: ACTIVE, FP, SYNC, BP.
- Vertical counter v advances when h wraps, and runs 0..V_TOTAL-1 with the same segment order.
- Sync asserted:
  - Horizontal: H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - Vertical: the analogous v window.
- Visible region: h<H_ACTIVE and v<V_ACTIVE.
- Address generation is incremental; no multiplier.
  - xs counts 0..SCALE-1 within a pixel.
  - col_addr = line_base + h/SCALE.
  - line_base advances by H_ACTIVE/SCALE after every SCALE-th visible line.
  - line_base clears at the v wrap.
- rd_o pulses on each visible tick where xs=0, with addr_o valid in that same cycle.
- The data pipeline is RD_LAT pixel ticks deep.
  - pxl_i is sampled on the tick RD_LAT ticks after the fetch. Replicated pixels reuse the last sampled word.
  - hs, vs, blank and frame are delayed by the same RD_LAT ticks so that all outputs stay aligned.
- Outside the visible region, r_o, g_o and b_o are 0, regardless of pxl_i.
- en_i=0:
  - The divider, counters, line_base and pipeline clear synchronously.
  - Outputs go to their reset values.
  - When en_i rises, the scan restarts at h=v=0.
- Reset values: hs_o = vs_o = ~SYNC_POL; blank_o=0; r_o, g_o, b_o = 0; addr_o=0; rd_o=0; frame_o=0; sync_o=0.

## Timing
- All outputs are registered and change only on clk_i edges where a tick fires. The exceptions are rd_o and frame_o, which return to 0 on the next clk.
- hs_o, vs_o and blank_o each hold for exactly CLK_DIV clk cycles per pixel.
- Latency from the scan position to the DAC pins is RD_LAT+1 ticks. This is identical for sync, blank and colour.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk cycles. For the defaults this is 800*525*2 = 840000.
- Wrap boundaries:
  - The h wrap and v wrap happen on the same tick at the frame end. The next tick shows h=0, v=0, and frame_o pulses RD_LAT+1 ticks later.
  - addr_o wraps to 0 at the frame start and never exceeds H_ACTIVE*V_ACTIVE/SCALE² − 1.
- rst_i mid-frame: all outputs take their reset values immediately (asynchronous). After release, the scan begins at h=v=0 on the first tick.
- en_i and rst_i simultaneously: rst_i dominates.

## Structure
- vga_pkg holds:
  - typedef scan_seg_t {SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP};
  - function for computing totals and sync windows;
  - elaboration-time parameter checks.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical).
  - Parameters: active/fp/sync/bp.
  - Inputs: clk_i, rst_i, clr_i, adv_i.
  - Outputs: count, segment, sync, wrap.
- The top level holds the divider, address generator, RD_LAT pipeline and output registers.

## Test plan
- Default parameters, en_i=1:
  - hs_o low for 192 clk per line.
  - Line period 1600 clk.
  - vs_o low for 2 lines (3200 clk).
  - blank_o high for 1280 clk per line.
- SCALE=2:
  - Line 0 fetches addresses 0..319, with rd_o every 4 clk.
  - Line 1 repeats 0..319.
  - Line 2 starts at 320.
  - The last fetch of the frame is at 76799, and the next frame starts at 0.
- RD_LAT=3, with a memory model returning data = addr:
  - The first visible r_o/g_o/b_o word equals 0, coincident with blank_o rising.
  - The colour is 0 whenever blank_o=0.
- CLK_DIV=1 with SYNC_POL=1:
  - hs_o is high for 96 clk.
  - Idle and reset level of hs_o is 0.
  - Frame period 420000 clk, with frame_o once per frame.
- Assert rst_i at h=300, v=200:
  - Outputs immediately at reset values.
  - After release, the first hs_o assertion occurs 656 ticks (1312 clk) after the first tick.
- Drop en_i for 10 clk mid-line:
  - Outputs idle while en_i is low.
  - After re-enable, addr_o restarts at 0 and frame_o pulses at the first visible pixel.
